serpent_dec_ctrl: RTL and testbench

Sequencer for the iterative Serpent decryption datapath (key mix, inverse S-box and inverse linear transform, one round step per iteration). It accepts a 128-bit ciphertext block over a valid/ready handshake and holds the working state register. It walks the round index 32 down to 0, fetching subkey K[r] from the key schedule and driving the round index to the datapath. It returns the plaintext over a second valid/ready handshake, and sits between the XTS tweak/mode logic and the round datapath.

---
 rtl/serpent_pkg.sv | 15 +
 rtl/serpent_key_wait_cnt.sv | 29 ++
 rtl/serpent_dec_ctrl.sv | 126 ++++++++++++
 tb/tb_serpent_dec_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// Shared constants and state encoding for the Serpent decryption sequencer.
package serpent_pkg;

    localparam int unsigned BLK_W      = 128;
    localparam int unsigned RND_W      = 6;
    localparam int unsigned LAST_ROUND = 32;

    typedef enum logic [1:0] {
        IDLE,
        KWAIT,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/serpent_key_wait_cnt.sv
// Down-counter covering the key schedule latency before each round step.
module serpent_key_wait_cnt #(
    parameter int unsigned KEY_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = $clog2(KEY_LAT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(KEY_LAT);
        end else if (en && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // high in the cycle whose closing edge takes the count to zero
    assign done = en && (cnt == CW'(1));

endmodule

// File: rtl/serpent_dec_ctrl.sv
// Round sequencer for the iterative Serpent decryption datapath.
module serpent_dec_ctrl
    import serpent_pkg::*;
#(
    parameter int unsigned KEY_LAT    = 1,
    parameter int unsigned LAST_ROUND = serpent_pkg::LAST_ROUND
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [serpent_pkg::BLK_W-1:0] i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [serpent_pkg::BLK_W-1:0] o_data,
    output logic [serpent_pkg::RND_W-1:0] o_key_idx,
    input  logic [serpent_pkg::BLK_W-1:0] i_subkey,
    output logic [serpent_pkg::RND_W-1:0] o_round,
    output logic [serpent_pkg::BLK_W-1:0] o_dp_state,
    output logic [serpent_pkg::BLK_W-1:0] o_dp_key,
    input  logic [serpent_pkg::BLK_W-1:0] i_dp_next,
    output logic                          o_busy
);

    localparam logic [RND_W-1:0] TOP = RND_W'(LAST_ROUND);

    state_t           st;
    state_t           nxt;
    logic             accept;
    logic             step;
    logic             kload;
    logic             kdone;
    logic             in_wait;
    logic [RND_W-1:0] r;
    logic [RND_W-1:0] key_idx;
    logic [BLK_W-1:0] data_q;
    logic [BLK_W-1:0] dp_key;

    assign in_wait = (st == KWAIT);
    assign kload   = accept | step;

    serpent_key_wait_cnt #(
        .KEY_LAT(KEY_LAT)
    ) u_cnt (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .load (kload),
        .en   (in_wait),
        .done (kdone)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt    = st;
        accept = 1'b0;
        step   = 1'b0;
        unique case (st)
            IDLE: begin
                if (i_valid) begin
                    accept = 1'b1;
                    nxt    = KWAIT;
                end
            end
            KWAIT: begin
                if (kdone) nxt = ROUND;
            end
            ROUND: begin
                if (r == '0) begin
                    nxt = DONE;
                end else begin
                    step = 1'b1;
                    nxt  = KWAIT;
                end
            end
            DONE: begin
                if (i_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        // abort beats everything, including a pending accept
        if (i_flush) begin
            nxt    = IDLE;
            accept = 1'b0;
            step   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            dp_key  <= '0;
            r       <= TOP;
            key_idx <= TOP;
        end else begin
            if (accept) begin
                data_q  <= i_data;
                r       <= TOP;
                key_idx <= TOP;
            end
            if (step) begin
                r       <= r - RND_W'(1);
                key_idx <= r - RND_W'(1);
            end
            if (in_wait && kdone) dp_key <= i_subkey;
            if (st == ROUND && !i_flush) data_q <= i_dp_next;
        end
    end

    assign o_ready    = (st == IDLE);
    assign o_valid    = (st == DONE);
    assign o_busy     = (st != IDLE);
    assign o_data     = data_q;
    assign o_dp_state = data_q;
    assign o_dp_key   = dp_key;
    assign o_round    = r;
    assign o_key_idx  = key_idx;

endmodule

// File: tb/tb_serpent_dec_ctrl.sv
// Directed bench: two controllers (KEY_LAT 1 and 3) against an XOR datapath model.
module tb_serpent_dec_ctrl;

    typedef struct {
        int           g;
        logic [127:0] data;
        int           hold;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] KALL = 128'h00000020_00000020_00000020_00000020;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         flush = '0;
    logic [1:0]         vin = '0;
    logic [1:0]         rdy;
    logic [1:0][127:0]  din = '0;
    logic [1:0]         vout;
    logic [1:0]         rin = '0;
    logic [1:0][127:0]  dout;
    logic [1:0][5:0]    kidx;
    logic [1:0][127:0]  subkey;
    logic [1:0][5:0]    round;
    logic [1:0][127:0]  dps;
    logic [1:0][127:0]  dpk;
    logic [1:0][127:0]  dpn;
    logic [1:0]         busy;

    int total = 0;
    int bad = 0;
    int lat_exp[2] = '{67, 133};

    always #5 clk = ~clk;

    function automatic logic [127:0] kfun(input logic [5:0] r);
        return {4{26'h0, r}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int KL = (g == 0) ? 1 : 3;

        logic [5:0]   d0 = '0;
        logic [5:0]   d1 = '0;
        logic [5:0]   last_idx = '0;
        logic         was_busy = 1'b0;
        logic         last_vout = 1'b0;
        logic [127:0] last_key = '0;
        int           steps = 0;

        serpent_dec_ctrl #(
            .KEY_LAT   (KL),
            .LAST_ROUND(32)
        ) dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_flush   (flush[g]),
            .i_valid   (vin[g]),
            .o_ready   (rdy[g]),
            .i_data    (din[g]),
            .o_valid   (vout[g]),
            .i_ready   (rin[g]),
            .o_data    (dout[g]),
            .o_key_idx (kidx[g]),
            .i_subkey  (subkey[g]),
            .o_round   (round[g]),
            .o_dp_state(dps[g]),
            .o_dp_key  (dpk[g]),
            .i_dp_next (dpn[g]),
            .o_busy    (busy[g])
        );

        // key schedule: the subkey for an index is only right KL edges later
        always @(posedge clk) begin
            d0 <= kidx[g];
            d1 <= d0;
        end
        if (KL == 1) begin : g_k1
            assign subkey[g] = kfun(kidx[g]);
        end else begin : g_k3
            assign subkey[g] = kfun(d1);
        end
        assign dpn[g] = dps[g] ^ dpk[g];

        always @(negedge clk) begin
            if (rst_n && busy[g]) begin
                if (!was_busy) begin
                    chk("idx_start", kidx[g], 32);
                    steps = 0;
                end else if (kidx[g] != last_idx) begin
                    chk("idx_step", kidx[g], last_idx - 6'd1);
                    steps++;
                end
                if (dpk[g] != last_key) chk("key_capture", dpk[g], kfun(round[g]));
                if (vout[g] && !last_vout) chk("idx_steps", steps, 32);
            end
            last_idx  = kidx[g];
            was_busy  = rst_n && busy[g];
            last_key  = dpk[g];
            last_vout = vout[g];
        end
    end

    task automatic check_idle_reset(input int g);
        chk("rst_flags", {rdy[g], vout[g], busy[g]}, 3'b100);
        chk("rst_round", round[g], 32);
        chk("rst_kidx", kidx[g], 32);
        chk("rst_data", dout[g], 0);
        chk("rst_dpkey", dpk[g], 0);
    endtask

    task automatic run_block(input int g, input logic [127:0] data,
                             input int hold, input logic [127:0] exp);
        int k;
        bit ok;
        k = 0;
        while (!rdy[g] && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before", rdy[g], 1);
        vin[g] = 1'b1;
        din[g] = data;
        @(posedge clk); #1;
        vin[g] = 1'b0;
        chk("accept_busy", busy[g], 1);
        k = 0;
        while (!vout[g] && k < 300) begin
            vin[g] = (k % 5 == 2);
            din[g] = {4{$urandom}};
            @(posedge clk); #1;
            k++;
        end
        vin[g] = 1'b0;
        // k+1: the first edge that can complete the output transfer
        chk("latency", k + 1, lat_exp[g]);
        chk("plaintext", dout[g], exp);
        chk("round_end", round[g], 0);
        ok = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (vout[g] !== 1'b1 || dout[g] !== exp) ok = 1'b0;
        end
        chk("hold_stable", ok, 1);
        rin[g] = 1'b1;
        @(posedge clk); #1;
        rin[g] = 1'b0;
        chk("done_drop", {vout[g], rdy[g], busy[g]}, 3'b010);
    endtask

    initial begin
        vec_t tbl[5];
        int k;
        tbl[0] = '{0, 128'h0, 0, KALL};
        tbl[1] = '{0, {128{1'b1}}, 2, 128'hffffffdf_ffffffdf_ffffffdf_ffffffdf};
        tbl[2] = '{1, 128'h01234567_89abcdef_fedcba98_76543210, 0,
                   128'h01234547_89abcdcf_fedcbab8_76543230};
        tbl[3] = '{1, 128'hdeadbeef_cafef00d_00000020_12345678, 10,
                   128'hdeadbecf_cafef02d_00000000_12345658};
        tbl[4] = '{0, KALL, 10, 128'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_reset(0);
        check_idle_reset(1);

        flush[0] = 1'b1;
        vin[0] = 1'b1;
        din[0] = 128'h55;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        vin[0] = 1'b0;
        chk("flush_wins", {busy[0], rdy[0]}, 2'b01);

        for (int i = 0; i < 5; i++)
            run_block(tbl[i].g, tbl[i].data, tbl[i].hold, tbl[i].exp);

        // abort at round 15, then a clean block from round 32
        vin[0] = 1'b1;
        din[0] = 128'h1234;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        k = 0;
        while (round[0] != 6'd15 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_r15", round[0], 15);
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        chk("flush_idle", {vout[0], rdy[0], busy[0]}, 3'b010);
        run_block(0, 128'hffff0000_0000ffff_a5a5a5a5_00000001, 0,
                  128'hffff0020_0000ffdf_a5a5a585_00000021);

        // asynchronous reset in the middle of the first KWAIT
        vin[1] = 1'b1;
        din[1] = 128'hbeef;
        @(posedge clk); #1;
        vin[1] = 1'b0;
        @(posedge clk); #1;
        chk("mid_kwait", busy[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(1, 128'h0, 3, KALL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
